dm_access_ctrl: RTL and testbench
=================================

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; all state SHALL update on the rising edge of clk, and reset SHALL act immediately.
REQ-002 The module SHALL have the following ports, clock and reset first:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
req  in  1  access request, sampled only in IDLE.
op  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 sw, 110 sb, 111 sh.
addr  in  32  byte address.
wdata  in  32  store data; sb uses [7:0], sh uses [15:0].
pc  in  32  PC of the requesting instruction.
busy  out  1  high in every non-IDLE state.
done  out  1  one-cycle completion pulse.
rdata  out  32  extended load result.
misalign  out  1  alignment fault flag, valid while done=1.
mem_pc  out  32  latched pc, driven to memory for write trace.
mem_we  out  1  word write enable to the memory.
mem_addr  out  32  word address {addr_l[31:2],2'b00}.
mem_wdata  out  32  word to write.
mem_rdata  in  32  word read data, combinational from mem_addr.

Function
REQ-003 The FSM SHALL have four states: IDLE, ACC, WR and DONE.
REQ-004 In IDLE, req=1 at a clock edge SHALL latch op, addr, wdata and pc, and SHALL move the FSM to ACC.
REQ-005 req SHALL be ignored in every state except IDLE.
REQ-006 In ACC, a load (lw, lb, lbu, lh, lhu) SHALL register the extracted mem_rdata into rdata and go to DONE.
REQ-007 In ACC, sw SHALL assert mem_we with mem_wdata equal to the latched wdata and go to DONE.
REQ-008 In ACC, sb and sh SHALL keep mem_we=0, register mem_rdata with the target lane replaced into a merge buffer, and go to WR.
REQ-009 In WR, the FSM SHALL assert mem_we with mem_wdata equal to the merge buffer and go to DONE.
REQ-010 DONE SHALL assert done=1 for exactly one cycle and return to IDLE.
REQ-011 mem_we SHALL be decoded from the current state and latched op only, never directly from req.
REQ-012 Latency from the req-sampling edge to the done cycle SHALL be 2 cycles for loads and sw, and 3 cycles for sb and sh.
REQ-013 Lanes SHALL be little-endian: byte n is [8n+7:8n]; halfword addr[1]=0 is [15:0] and addr[1]=1 is [31:16].
REQ-014 lb and lh SHALL sign-extend, lbu and lhu SHALL zero-extend, and lw SHALL pass the full word.
REQ-015 rdata SHALL hold its value until the next load completes; stores SHALL leave rdata unchanged.
REQ-016 The merge for sb and sh SHALL preserve every byte outside the written lane bit-exactly.
REQ-017 mem_pc and mem_addr SHALL be driven from latched values and SHALL stay stable throughout ACC, WR and DONE.

Reset
REQ-018 Reset SHALL force IDLE and clear busy, done, rdata, misalign, mem_we, mem_pc, mem_addr, mem_wdata and the merge buffer to 0.
REQ-019 Reset asserted in ACC or WR SHALL drop mem_we immediately, so no write occurs at the following edge and an in-flight sb or sh leaves memory unmodified.

Configuration
REQ-020 With macro DM_MISALIGN_CHECK_EN defined, the module SHALL check alignment of the accepted request in ACC: lw and sw fault when addr[1:0]!=0, and lh, lhu and sh fault when addr[0]!=0.
REQ-021 With the macro defined, a faulting request SHALL skip memory entirely (mem_we=0), go ACC->DONE, raise misalign=1 together with done, and leave rdata unchanged.
REQ-022 Without the macro, low address bits not used for lane selection SHALL be ignored, and misalign SHALL be constant 0.
REQ-023 The misalign port SHALL exist in both builds.

Verification
REQ-024 Load scenario: memory word 0x10 = 0x8765F0A1; lb addr 0x13 -> rdata 0xFFFFFF87; lbu addr 0x13 -> 0x00000087; lh addr 0x10 -> 0xFFFFF0A1; each with done 2 cycles after req.
REQ-025 Read-modify-write scenario: word 0x20 = 0x11223344; sb addr 0x21, wdata 0xAB -> word 0x1122AB44; sh addr 0x22, wdata 0xBEEF -> word 0xBEEFAB44; done 3 cycles after req; mem_we high only in WR.
REQ-026 Store scenario: sw addr 0x3FC, wdata 0xDEADBEEF -> one mem_we cycle in ACC, then lw 0x3FC -> rdata 0xDEADBEEF; rdata is unchanged by the sw.
REQ-027 Reset scenario: reset asserted during WR of sb addr 0x21 -> mem_we falls immediately, word 0x20 is unchanged, the FSM is in IDLE and all outputs read 0.
REQ-028 Ignored-request scenario: req held high through ACC, WR and DONE -> exactly one access is performed, and a second access starts only after the FSM returns to IDLE.
REQ-029 Misalignment scenario, with DM_MISALIGN_CHECK_EN: lw addr 0x22 -> misalign=1 with done, no write, rdata unchanged; without the macro, the same request returns word 0x20.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: single-port data-memory access controller for a simple core.
//
// Accepts one load/store request at a time and sequences it against a word-wide
// memory whose read data is combinational from mem_addr.
//   Loads and sw: IDLE -> ACC -> DONE
//   sb and sh:    IDLE -> ACC -> WR -> DONE (read-modify-write of one word)
//
// Optional feature: define DM_MISALIGN_CHECK_EN to enable the alignment check.
// A faulting request then skips memory and completes with misalign=1.
// In the default build misalign is tied to 0.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req, op, addr,      request and its operands, sampled only in IDLE
//   wdata, pc
//   busy                high in every non-IDLE state
//   done                one-cycle completion pulse
//   rdata               extended load result, held until the next load
//   misalign            alignment fault flag, valid while done=1
//   mem_pc              latched pc for memory write trace
//   mem_we              word write enable
//   mem_addr            word-aligned address
//   mem_wdata           word to write
//   mem_rdata           word read data, combinational from mem_addr
module dm_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic [31:0] mem_pc,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SB  = 3'b110;
    localparam logic [2:0] OP_SH  = 3'b111;

    logic [1:0]  state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] pc_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;

    logic        is_load;
    logic        is_sub_store;
    logic        fault;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign is_load      = (op_q <= OP_LHU);
    assign is_sub_store = (op_q == OP_SB) || (op_q == OP_SH);

`ifdef DM_MISALIGN_CHECK_EN
    logic misalign_q;

    always_comb begin
        fault = 1'b0;
        unique case (op_q)
            OP_LW, OP_SW:        fault = (addr_q[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH: fault = addr_q[0];
            default:             fault = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (state_q == ACC) begin
            misalign_q <= fault;
        end
    end

    assign misalign = misalign_q & done;
`else
    // Unused low address bits are simply ignored in this build.
    assign fault    = 1'b0;
    assign misalign = 1'b0;
`endif

    // Lane extraction from the addressed word (little-endian lanes).
    always_comb begin
        byte_val = 8'h00;
        unique case (addr_q[1:0])
            2'd0: byte_val = mem_rdata[7:0];
            2'd1: byte_val = mem_rdata[15:8];
            2'd2: byte_val = mem_rdata[23:16];
            2'd3: byte_val = mem_rdata[31:24];
            default: byte_val = 8'h00;
        endcase
        half_val = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        load_val = mem_rdata;
        unique case (op_q)
            OP_LB:   load_val = {{24{byte_val[7]}}, byte_val};
            OP_LBU:  load_val = {24'h000000, byte_val};
            OP_LH:   load_val = {{16{half_val[15]}}, half_val};
            OP_LHU:  load_val = {16'h0000, half_val};
            default: load_val = mem_rdata;
        endcase
    end

    // Replace only the target lane; every other byte passes through untouched.
    always_comb begin
        merged = mem_rdata;
        if (op_q == OP_SB) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (op_q == OP_SH) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = ACC;
            ACC:     state_d = (!fault && is_sub_store) ? WR : DONE;
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            pc_q    <= 32'h0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
                pc_q    <= pc;
            end
            if (state_q == ACC && !fault) begin
                if (is_load)      rdata_q <= load_val;
                if (is_sub_store) merge_q <= merged;
            end
        end
    end

    // Write enable comes from registered state only, so an asynchronous reset
    // removes it in the same instant the state returns to IDLE.
    assign mem_we    = ((state_q == ACC) && (op_q == OP_SW) && !fault) || (state_q == WR);
    assign mem_wdata = (state_q == WR) ? merge_q : wdata_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_pc    = pc_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios plus randomized
// accesses checked against a word-array reference model.
module tb_dm_access_ctrl;

    localparam logic [2:0] LW = 3'd0, LB = 3'd1, LBU = 3'd2, LH = 3'd3, LHU = 3'd4;
    localparam logic [2:0] SW = 3'd5, SB = 3'd6, SH = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr, wdata, pc;
    logic        busy, done, misalign, mem_we;
    logic [31:0] rdata, mem_pc, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] exp_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dm_access_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .misalign  (misalign),
        .mem_pc    (mem_pc),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic bit ref_fault(input logic [2:0] o, input logic [31:0] a);
`ifdef DM_MISALIGN_CHECK_EN
        if (o == LW || o == SW) return a[1:0] != 2'b00;
        if (o == LH || o == LHU || o == SH) return a[0];
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [31:0] w,
                                             input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (o)
            LB:      return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            LBU:     return b;
            LH:      return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            LHU:     return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] o, input logic [31:0] w,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (o == SW) return d;
        if (o == SB) begin
            sh   = 8 * a[1:0];
            mask = 32'hFF << sh;
            return (w & ~mask) | ((d & 32'hFF) << sh);
        end
        sh   = 16 * a[1];
        mask = 32'hFFFF << sh;
        return (w & ~mask) | ((d & 32'hFFFF) << sh);
    endfunction

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx]     = w;
        ref_mem[idx] = w;
    endtask

    // One complete access with req pulsed for a single sampling edge.
    task automatic run_access(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] p);
        int  idx, exp_lat, exp_writes, exp_we_cyc, got_lat, writes, we_cyc;
        bit  flt;
        idx        = int'(a[9:2]);
        flt        = ref_fault(o, a);
        exp_lat    = (!flt && (o == SB || o == SH)) ? 3 : 2;
        exp_writes = (!flt && o >= SW) ? 1 : 0;
        exp_we_cyc = (exp_writes == 0) ? 0 : ((o == SW) ? 1 : 2);
        if (!flt) begin
            if (o < SW) exp_rdata = ref_load(o, ref_mem[idx], a);
            else        ref_mem[idx] = ref_store(o, ref_mem[idx], a, d);
        end
        @(negedge clk);
        req = 1'b1; op = o; addr = a; wdata = d; pc = p;
        @(posedge clk);
        got_lat = 0; writes = 0; we_cyc = 0;
        for (int cyc = 1; cyc <= 8 && got_lat == 0; cyc++) begin
            @(negedge clk);
            req = 1'b0;
            if (cyc == 1) begin
                check_eq("busy_acc", busy, 1);
                check_eq("mem_addr", mem_addr, {a[31:2], 2'b00});
            end
            if (mem_we) begin
                writes++;
                we_cyc = cyc;
            end
            if (done) begin
                got_lat = cyc;
                check_eq("misalign", misalign, flt);
                check_eq("mem_pc", mem_pc, p);
                check_eq("rdata", rdata, exp_rdata);
                check_eq("mem_word", mem[idx], ref_mem[idx]);
            end
        end
        check_eq("latency", got_lat, exp_lat);
        check_eq("writes", writes, exp_writes);
        check_eq("we_cycle", we_cyc, exp_we_cyc);
    endtask

    initial begin
        int idle_cyc, writes, dones;
        reset = 1'b1; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0; pc = 32'h0;
        exp_rdata = 32'h0;
        for (int i = 0; i < 256; i++) set_word(i, $urandom);
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", mem_wdata, 0);
        check_eq("rst_misalign", misalign, 0);
        reset = 1'b0;

        // Loads with sign/zero extension.
        set_word(32'h10 >> 2, 32'h8765_F0A1);
        run_access(LB, 32'h13, 32'h0, 32'h100);
        check_eq("lb_const", rdata, 32'hFFFF_FF87);
        run_access(LBU, 32'h13, 32'h0, 32'h104);
        check_eq("lbu_const", rdata, 32'h0000_0087);
        run_access(LH, 32'h10, 32'h0, 32'h108);
        check_eq("lh_const", rdata, 32'hFFFF_F0A1);

        // Read-modify-write stores.
        set_word(32'h20 >> 2, 32'h1122_3344);
        run_access(SB, 32'h21, 32'h0000_00AB, 32'h10C);
        check_eq("sb_const", mem[8], 32'h1122_AB44);
        run_access(SH, 32'h22, 32'h0000_BEEF, 32'h110);
        check_eq("sh_const", mem[8], 32'hBEEF_AB44);

        // Full-word store then load back.
        run_access(SW, 32'h3FC, 32'hDEAD_BEEF, 32'h114);
        check_eq("sw_rdata_kept", rdata, 32'hFFFF_F0A1);
        run_access(LW, 32'h3FC, 32'h0, 32'h118);
        check_eq("lw_const", rdata, 32'hDEAD_BEEF);

        // Misaligned word load.
        run_access(LW, 32'h22, 32'h0, 32'h11C);
`ifdef DM_MISALIGN_CHECK_EN
        check_eq("misal_rdata", rdata, 32'hDEAD_BEEF);
`else
        check_eq("misal_rdata", rdata, 32'hBEEF_AB44);
`endif

        // Reset asserted during WR of an sb.
        set_word(8, 32'h1122_3344);
        @(negedge clk);
        req = 1'b1; op = SB; addr = 32'h21; wdata = 32'hAB; pc = 32'h120;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        check_eq("wr_we", mem_we, 1);
        reset = 1'b1;
        #1;
        check_eq("rst_wr_we", mem_we, 0);
        check_eq("rst_wr_busy", busy, 0);
        check_eq("rst_wr_rdata", rdata, 0);
        check_eq("rst_wr_pc", mem_pc, 0);
        check_eq("rst_wr_addr", mem_addr, 0);
        check_eq("rst_wr_wdata", mem_wdata, 0);
        @(negedge clk);
        check_eq("rst_wr_mem", mem[8], 32'h1122_3344);
        reset = 1'b0;
        exp_rdata = 32'h0;

        // req held high: exactly one access, next one only after IDLE.
        set_word(12, 32'hCAFE_0000);
        ref_mem[12] = ref_store(SB, ref_mem[12], 32'h30, 32'h5A);
        @(negedge clk);
        req = 1'b1; op = SB; addr = 32'h30; wdata = 32'h5A; pc = 32'h124;
        @(posedge clk);
        writes = 0; dones = 0; idle_cyc = 0;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            if (mem_we) writes++;
            if (done) dones++;
            if (!busy && idle_cyc == 0) idle_cyc = cyc;
        end
        check_eq("hold_writes", writes, 1);
        check_eq("hold_dones", dones, 1);
        check_eq("hold_idle_cyc", idle_cyc, 4);
        @(negedge clk);
        check_eq("hold_restart", busy, 1);
        req = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("hold_done2", done, 1);
        check_eq("hold_mem", mem[12], ref_mem[12]);

        // Randomized accesses against the reference model.
        for (int i = 0; i < 80; i++) begin
            run_access(3'($urandom_range(0, 7)), 32'($urandom_range(0, 32'h3FF)), $urandom,
                       $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
